// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the unified memory port arbiter
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Read data returned to the requester when an access is aborted by timeout
    localparam int ABORT_DATA = 0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - single-port memory request/response bus
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;

    modport master (output m_req, m_we, m_addr, m_wdata, input m_rdata, m_ready);
    modport slave  (input m_req, m_we, m_addr, m_wdata, output m_rdata, m_ready);
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// rtl/mem_port_arbiter_wait_timer.sv - saturating wait-cycle counter with expiry flag
module wait_timer #(
    parameter int TW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TW'(TIMEOUT));
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and load/store onto one memory port and drives pipeline stalls
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [AW-1:0]       if_addr,
    input  logic                if_flush,
    output logic [DW-1:0]       if_rdata,
    output logic                if_valid,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [AW-1:0]       d_addr,
    input  logic [DW-1:0]       d_wdata,
    output logic [DW-1:0]       d_rdata,
    output logic                d_valid,
    mem_port_arbiter_if.master  mem,
    output logic                stall_fetch,
    output logic                stall_pipe,
    output logic                err
);
    logic [1:0] state;
    logic       discard;
    logic       expired;
    logic       waiting;
    logic       d_req;

    assign d_req   = d_read | d_write;
    assign waiting = (state == ST_DATA) || (state == ST_FETCH);

    wait_timer #(.TW(TW), .TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!waiting),
        .en      (waiting && !mem.m_ready),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem.m_req   <= 1'b0;
            mem.m_we    <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_wdata <= '0;
            if_valid    <= 1'b0;
            d_valid     <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            err         <= 1'b0;
            discard     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (d_req) begin
                        state       <= ST_DATA;
                        mem.m_req   <= 1'b1;
                        mem.m_we    <= d_write;
                        mem.m_addr  <= d_addr;
                        mem.m_wdata <= d_wdata;
                    end else if (if_req && !if_flush) begin
                        state       <= ST_FETCH;
                        mem.m_req   <= 1'b1;
                        mem.m_we    <= 1'b0;
                        mem.m_addr  <= if_addr;
                        mem.m_wdata <= '0;
                    end
                end
                ST_DATA: begin
                    if (mem.m_ready || expired) begin
                        state     <= ST_RESP;
                        mem.m_req <= 1'b0;
                        d_valid   <= 1'b0 | 1'b1;
                        if (!mem.m_we) begin
                            d_rdata <= mem.m_ready ? mem.m_rdata : DW'(ABORT_DATA);
                        end
                        if (!mem.m_ready) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (if_flush) begin
                        discard <= 1'b1;
                    end
                    if (mem.m_ready || expired) begin
                        state     <= ST_RESP;
                        mem.m_req <= 1'b0;
                        // A flush arriving on the completing edge must also suppress the response
                        if (!(discard || if_flush)) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem.m_ready ? mem.m_rdata : DW'(ABORT_DATA);
                        end
                        if (!mem.m_ready) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    discard <= 1'b0;
                end
            endcase
        end
    end

    assign stall_pipe  = d_req & ~d_valid;
    assign stall_fetch = (if_req & ~if_valid) | stall_pipe;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a reference memory model
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        d_read, d_write, d_valid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        stall_fetch, stall_pipe, err;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) mbus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(255), .TW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_flush    (if_flush),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_valid     (d_valid),
        .mem         (mbus.master),
        .stall_fetch (stall_fetch),
        .stall_pipe  (stall_pipe),
        .err         (err)
    );

    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Unwritten locations read back a fixed scramble of their address
    function automatic logic [31:0] dflt(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem     [logic [31:0]];

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          abort;
    } dexp_t;

    dexp_t       dq[$];
    logic [31:0] iq[$];
    logic [31:0] last_load = 32'h0;

    // Memory responder: wait_cfg >= 0 fixed waits, -1 random 0..3, -2 never ready
    int          wait_cfg = 0;
    bit          busy = 1'b0;
    int          waited, target;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;
    logic [31:0] acc_addr = 32'h0, acc_wdata = 32'h0;
    logic        acc_we = 1'b0;

    initial begin
        mbus.m_ready = 1'b0;
        mbus.m_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mbus.m_req) begin
                mbus.m_ready = 1'b0;
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy    = 1'b1;
                    waited  = 0;
                    target  = (wait_cfg == -1) ? int'($urandom_range(0, 3)) :
                              (wait_cfg == -2) ? (1 << 30) : wait_cfg;
                    s_addr  = mbus.m_addr;
                    s_we    = mbus.m_we;
                    s_wdata = mbus.m_wdata;
                end
                mbus.m_ready = (waited >= target);
                if (mbus.m_ready) begin
                    if (waited > 0) begin
                        chk("m_addr_hold", mbus.m_addr, s_addr);
                        chk("m_we_hold", {31'h0, mbus.m_we}, {31'h0, s_we});
                        chk("m_wdata_hold", mbus.m_wdata, s_wdata);
                    end
                    if (mbus.m_we) mem[mbus.m_addr] = mbus.m_wdata;
                    else mbus.m_rdata = mem_rd(mbus.m_addr);
                    acc_addr  = mbus.m_addr;
                    acc_we    = mbus.m_we;
                    acc_wdata = mbus.m_wdata;
                end
                waited++;
            end
        end
    end

    // Monitor: pops the expected response whenever a valid pulse is presented
    initial begin
        dexp_t       e;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (!rst && d_valid) begin
                if (dq.size() == 0) begin
                    chk("d_valid_unexpected", {31'h0, d_valid}, 32'h0);
                end else begin
                    e = dq.pop_front();
                    chk("d_rdata", d_rdata, e.rdata);
                    if (e.abort) begin
                        chk("err_on_abort", {31'h0, err}, 32'h1);
                    end else begin
                        chk("d_m_addr", acc_addr, e.addr);
                        chk("d_m_we", {31'h0, acc_we}, {31'h0, e.we});
                        if (e.we) chk("d_m_wdata", acc_wdata, e.wdata);
                    end
                end
            end
            if (!rst && if_valid) begin
                if (iq.size() == 0) begin
                    chk("if_valid_unexpected", {31'h0, if_valid}, 32'h0);
                end else begin
                    a = iq.pop_front();
                    chk("if_rdata", if_rdata, dflt(a));
                    chk("if_m_addr", acc_addr, a);
                    chk("if_m_we", {31'h0, acc_we}, 32'h0);
                end
            end
        end
    end

    task automatic data_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input bit abort, output int lat);
        dexp_t e;
        bit    done = 1'b0;
        e.we = we; e.addr = a; e.wdata = wd; e.abort = abort;
        if (abort) begin
            e.rdata = we ? last_load : 32'h0;
            if (!we) last_load = 32'h0;
        end else if (we) begin
            e.rdata = last_load;
            ref_mem[a] = wd;
        end else begin
            e.rdata = ref_rd(a);
            last_load = e.rdata;
        end
        dq.push_back(e);
        d_read = !we; d_write = we; d_addr = a; d_wdata = wd; lat = -1;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (d_valid) begin lat = n; done = 1'b1; end
            @(posedge clk);
            #1;
        end
        d_read = 1'b0; d_write = 1'b0;
        if (!done) chk("d_op_bound", {31'h0, done}, 32'h1);
    endtask

    task automatic fetch_op(input logic [31:0] a, input bit keep, input int flush_at, output int lat);
        bit done = 1'b0;
        bit dropped = 1'b0;
        iq.push_back(a);
        if_req = 1'b1; if_addr = a; lat = -1;
        for (int n = 0; n < 400 && !done; n++) begin
            if (n == flush_at) if_flush = 1'b1;
            @(negedge clk);
            if (if_valid) begin
                lat = n; done = 1'b1;
            end else if (if_flush) begin
                iq.delete(iq.size() - 1);
                dropped = 1'b1; done = 1'b1;
            end
            @(posedge clk);
            #1;
            if_flush = 1'b0;
        end
        if (!done) chk("if_op_bound", {31'h0, done}, 32'h1);
        if (!keep || dropped) if_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, l2;
        rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_req", {31'h0, mbus.m_req}, 32'h0);
        chk("rst_m_addr", mbus.m_addr, 32'h0);
        chk("rst_m_wdata", mbus.m_wdata, 32'h0);
        chk("rst_valids", {30'h0, if_valid, d_valid}, 32'h0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_stalls", {30'h0, stall_fetch, stall_pipe}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero-wait load with latency and stall profile
        mem[32'h40] = 32'h1234_5678;
        ref_mem[32'h40] = 32'h1234_5678;
        wait_cfg = 0;
        fork
            data_op(1'b0, 32'h40, 32'h0, 1'b0, lat);
            begin
                @(negedge clk);
                chk("t1_c0_m_req", {31'h0, mbus.m_req}, 32'h0);
                chk("t1_c0_stall", {30'h0, stall_fetch, stall_pipe}, 32'h3);
                @(negedge clk);
                chk("t1_c1_m_req", {31'h0, mbus.m_req}, 32'h1);
                chk("t1_c1_stall", {31'h0, stall_pipe}, 32'h1);
                @(negedge clk);
                chk("t1_c2_stall", {31'h0, stall_pipe}, 32'h0);
            end
        join
        chk("t1_lat", lat, 32'd2);

        // Store and fetch together, store wins, 3 wait states each
        wait_cfg = 3;
        fork
            data_op(1'b1, 32'h80, 32'hCAFE_F00D, 1'b0, lat);
            fetch_op(32'h100, 1'b0, -1, l2);
        join
        chk("t2_store_lat", lat, 32'd5);
        chk("t2_fetch_lat", l2, 32'd11);
        data_op(1'b0, 32'h80, 32'h0, 1'b0, lat);

        // Flush in IDLE blocks the fetch
        wait_cfg = 0;
        if_req = 1'b1; if_addr = 32'h300; if_flush = 1'b1;
        @(posedge clk);
        #1;
        if_req = 1'b0; if_flush = 1'b0;
        @(negedge clk);
        chk("t3_idle_flush_m_req", {31'h0, mbus.m_req}, 32'h0);
        @(posedge clk);
        #1;

        // Flush during an in-flight 4-wait fetch, then redirect
        wait_cfg = 4;
        if_req = 1'b1; if_addr = 32'h200;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        fetch_op(32'h204, 1'b0, -1, lat);
        chk("t3_redirect_lat", lat, 32'd10);

        // Continuous zero-wait fetch stream
        wait_cfg = 0;
        for (int i = 0; i < 20; i++) begin
            fetch_op(32'h1000 + 32'(4 * i), (i < 19), -1, lat);
            chk("t6_fetch_lat", lat, 32'd2);
        end

        // Timeout abort, sticky err
        chk("t4_err_before", {31'h0, err}, 32'h0);
        wait_cfg = -2;
        data_op(1'b0, 32'h44, 32'h0, 1'b1, lat);
        chk("t4_abort_lat", lat, 32'd257);
        chk("t4_err_set", {31'h0, err}, 32'h1);
        wait_cfg = 0;
        data_op(1'b0, 32'h48, 32'h0, 1'b0, lat);
        chk("t4_err_sticky", {31'h0, err}, 32'h1);

        // Reset in the middle of a data access
        wait_cfg = -2;
        d_read = 1'b1; d_addr = 32'h50;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t5_m_req_before", {31'h0, mbus.m_req}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_m_req_after", {31'h0, mbus.m_req}, 32'h0);
        chk("t5_valids", {30'h0, if_valid, d_valid}, 32'h0);
        chk("t5_err_clear", {31'h0, err}, 32'h0);
        chk("t5_stalls", {30'h0, stall_fetch, stall_pipe}, 32'h3);
        @(posedge clk);
        #1;
        rst = 1'b0; d_read = 1'b0; last_load = 32'h0;
        @(negedge clk);
        chk("t5_stalls_idle", {30'h0, stall_fetch, stall_pipe}, 32'h0);
        @(posedge clk);
        #1;

        // Randomized concurrent traffic with random waits and flushes
        wait_cfg = -1;
        fork
            begin
                int dl;
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    data_op(1'($urandom_range(0, 1)), 32'h400 + 32'(4 * $urandom_range(0, 15)),
                            $urandom, 1'b0, dl);
                end
            end
            begin
                int fl;
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    fetch_op(32'h2000 + 32'(4 * $urandom_range(0, 63)), 1'b0,
                             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1, fl);
                end
            end
        join
        repeat (8) @(posedge clk);
        chk("dq_drained", dq.size(), 32'h0);
        chk("iq_drained", iq.size(), 32'h0);
        chk("err_clean_run", {31'h0, err}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
